// File: rtl/func_arbiter.sv
// func_arbiter: shares a single `func` compute unit between NREQ requesters
// using round-robin arbitration. The arbiter handles one operation at a time:
//   1. Latch the winner's operands.
//   2. Pulse the unit's reset for one cycle.
//   3. Issue a one-cycle start pulse.
//   4. Wait for busy to clear.
//   5. Return the result with a one-cycle one-hot done pulse.
//
// Optional build macro FUNC_ARB_TIMEOUT_EN enables a watchdog on the busy wait.
// The watchdog adds parameter TIMEOUT_CYC and output err_o.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_i      asynchronous active-low reset
//   req_i      per-requester request level
//   a_bi/b_bi  packed operands, requester k at [k*W +: W]
//   gnt_o      one-hot grant, held for the whole operation
//   done_o     one-hot, one-cycle completion pulse
//   y_bo       result, held until the next done
//   err_o      watchdog expiry, pulsed with done_o (FUNC_ARB_TIMEOUT_EN only)
//   f_rst_o    active-high reset to `func`
//   f_a_bo/f_b_bo, f_start_o    operands and start pulse to `func`
//   f_busy_i   busy from `func` (any nonzero bit means busy)
//   f_y_bi     result from `func`
module func_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned A_W         = 8,
  parameter int unsigned B_W         = 8,
  parameter int unsigned Y_W         = 5
`ifdef FUNC_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NREQ-1:0]     req_i,
  input  logic [NREQ*A_W-1:0] a_bi,
  input  logic [NREQ*B_W-1:0] b_bi,
  output logic [NREQ-1:0]     gnt_o,
  output logic [NREQ-1:0]     done_o,
  output logic [Y_W-1:0]      y_bo,
`ifdef FUNC_ARB_TIMEOUT_EN
  output logic                err_o,
`endif
  output logic                f_rst_o,
  output logic [A_W-1:0]      f_a_bo,
  output logic [B_W-1:0]      f_b_bo,
  output logic                f_start_o,
  input  logic [1:0]          f_busy_i,
  input  logic [Y_W-1:0]      f_y_bi
);

  localparam int unsigned PTR_W = $clog2(NREQ);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_GUARD  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] win_q, win_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             f_rst_q, f_rst_d;
  logic [A_W-1:0]   f_a_q, f_a_d;
  logic [B_W-1:0]   f_b_q, f_b_d;
  logic             f_start_q, f_start_d;

`ifdef FUNC_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  logic             busy;
  logic             pick_found;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] ptr_next;

  assign busy     = |f_busy_i;
  assign ptr_next = (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + 1'b1;

  // Round-robin pick: first set request at or above the pointer, wrapping.
  always_comb begin
    logic [PTR_W-1:0] k;
    pick_found = 1'b0;
    pick_idx   = '0;
    k          = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = PTR_W'((32'(ptr_q) + i) % NREQ);
      if (!pick_found && req_i[k]) begin
        pick_found = 1'b1;
        pick_idx   = k;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    y_d       = y_q;
    f_rst_d   = 1'b0;
    f_a_d     = f_a_q;
    f_b_d     = f_b_q;
    f_start_d = 1'b0;
`ifdef FUNC_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          win_d           = pick_idx;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          f_a_d           = a_bi[pick_idx*A_W +: A_W];
          f_b_d           = b_bi[pick_idx*B_W +: B_W];
          f_rst_d         = 1'b1;
          state_d         = S_CLR;
        end
      end
      S_CLR: begin
        f_start_d = 1'b1;
        state_d   = S_LAUNCH;
      end
      S_LAUNCH: state_d = S_GUARD;
      // Busy is not yet valid here; the unit needs a cycle to raise it.
      S_GUARD: begin
`ifdef FUNC_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!busy) begin
          y_d     = f_y_bi;
          done_d  = gnt_q;
          state_d = S_RESP;
        end
`ifdef FUNC_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          y_d     = '1;
          done_d  = gnt_q;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        gnt_d   = '0;
        ptr_d   = ptr_next;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      y_q       <= '0;
      f_rst_q   <= 1'b1;
      f_a_q     <= '0;
      f_b_q     <= '0;
      f_start_q <= 1'b0;
`ifdef FUNC_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      y_q       <= y_d;
      f_rst_q   <= f_rst_d;
      f_a_q     <= f_a_d;
      f_b_q     <= f_b_d;
      f_start_q <= f_start_d;
`ifdef FUNC_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign gnt_o     = gnt_q;
  assign done_o    = done_q;
  assign y_bo      = y_q;
  assign f_rst_o   = f_rst_q;
  assign f_a_bo    = f_a_q;
  assign f_b_bo    = f_b_q;
  assign f_start_o = f_start_q;
`ifdef FUNC_ARB_TIMEOUT_EN
  assign err_o     = err_q;
`endif

endmodule

// File: tb/tb_func_arbiter.sv
// Testbench for func_arbiter.
// The `func` unit is stubbed. Its result is the rounded square root of operand A.
// Its busy time is chosen per operation, and it can be forced stuck-busy for the watchdog test.
// Arbitration is predicted from the round-robin rule on request vectors.
module tb_func_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned A_W  = 8;
  localparam int unsigned B_W  = 8;
  localparam int unsigned Y_W  = 5;
  localparam int unsigned PW   = $clog2(NREQ);

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_i;
  logic [NREQ*A_W-1:0] a_bi;
  logic [NREQ*B_W-1:0] b_bi;
  logic [NREQ-1:0]     gnt_o, done_o;
  logic [Y_W-1:0]      y_bo;
  logic                f_rst_o, f_start_o;
  logic [A_W-1:0]      f_a_bo;
  logic [B_W-1:0]      f_b_bo;
  logic [1:0]          f_busy_i;
  logic [Y_W-1:0]      f_y_bi;
`ifdef FUNC_ARB_TIMEOUT_EN
  logic                err_o;
`endif

  func_arbiter #(
    .NREQ(NREQ), .A_W(A_W), .B_W(B_W), .Y_W(Y_W)
`ifdef FUNC_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(16)
`endif
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .req_i(req_i), .a_bi(a_bi), .b_bi(b_bi),
    .gnt_o(gnt_o), .done_o(done_o), .y_bo(y_bo),
`ifdef FUNC_ARB_TIMEOUT_EN
    .err_o(err_o),
`endif
    .f_rst_o(f_rst_o), .f_a_bo(f_a_bo), .f_b_bo(f_b_bo), .f_start_o(f_start_o),
    .f_busy_i(f_busy_i), .f_y_bi(f_y_bi)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails     = 0;
  int model_ptr = 0;

  function automatic logic [Y_W-1:0] ref_func(input logic [A_W-1:0] a);
    int y = 0;
    while (y * y + y < int'(a)) y++;
    return Y_W'(y);
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (p + i) % NREQ;
      if (r[PW'(k)]) return k;
    end
    return -1;
  endfunction

  // Stub of the compute unit.
  int             stub_cnt = 0;
  logic [Y_W-1:0] stub_y = '0;
  int             lat_sel = 0;
  bit             stuck = 1'b0;
  always @(posedge clk) begin
    if (f_rst_o) begin
      stub_cnt <= 0;
      stub_y   <= '0;
    end else if (f_start_o) begin
      stub_cnt <= lat_sel;
      stub_y   <= ref_func(f_a_bo);
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
    end
  end
  assign f_busy_i = stuck ? 2'b01 : (stub_cnt == 0) ? 2'b00 : (stub_cnt[0] ? 2'b01 : 2'b10);
  assign f_y_bi   = (stub_cnt == 0) ? stub_y : (Y_W'(stub_cnt) ^ 5'h15);

  // Monotonic observation counters, sampled away from the active edge.
  int rst_cyc = 0, start_cyc = 0, multi_gnt = 0, done_cnt = 0, done_bad = 0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (f_rst_o) rst_cyc++;
      if (f_start_o) start_cyc++;
      if ($countones(gnt_o) > 1) multi_gnt++;
      if (done_o != '0) done_cnt++;
      if (done_o != '0 && done_o !== gnt_o) done_bad++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Runs one operation with the requests/operands already driven.
  task automatic run_op(input int lat, input bit scramble,
                        output logic [NREQ-1:0] g, output logic [NREQ-1:0] d,
                        output logic [Y_W-1:0] y, output logic [A_W-1:0] a_lat,
                        output logic [B_W-1:0] b_lat, output int cyc,
                        output int rsts, output int starts, output bit err, output bit to);
    int r0, s0;
    r0 = rst_cyc; s0 = start_cyc;
    lat_sel = lat;
    g = '0; d = '0; y = '0; a_lat = '0; b_lat = '0; cyc = 0; err = 1'b0; to = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (g == '0 && gnt_o != '0) begin
        g = gnt_o; a_lat = f_a_bo; b_lat = f_b_bo;
        if (scramble) begin
          a_bi  = $urandom;
          b_bi  = $urandom;
          req_i = NREQ'($urandom);
        end
      end
      if (done_o != '0) begin
        d = done_o; y = y_bo; cyc = n; to = 1'b0;
`ifdef FUNC_ARB_TIMEOUT_EN
        err = err_o;
`endif
        break;
      end
    end
    rsts = rst_cyc - r0; starts = start_cyc - s0;
  endtask

  task automatic test_reset;
    req_i = '0; a_bi = '0; b_bi = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (f_rst_o !== 1'b1) begin fails++; $display("FAIL reset_f_rst: got %b want 1", f_rst_o); end
    tests_run++; if (gnt_o !== '0) begin fails++; $display("FAIL reset_gnt: got %b want 0", gnt_o); end
    tests_run++; if (done_o !== '0) begin fails++; $display("FAIL reset_done: got %b want 0", done_o); end
    tests_run++; if (y_bo !== '0) begin fails++; $display("FAIL reset_y: got %0d want 0", y_bo); end
    tests_run++; if (f_a_bo !== '0 || f_b_bo !== '0) begin fails++; $display("FAIL reset_ops: got a=%0d b=%0d want 0", f_a_bo, f_b_bo); end
    tests_run++; if (f_start_o !== 1'b0) begin fails++; $display("FAIL reset_start: got %b want 0", f_start_o); end
`ifdef FUNC_ARB_TIMEOUT_EN
    tests_run++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err_o); end
`endif
    idle(3);
    rst_n = 1'b1;
    model_ptr = 0;
    idle(1);
    tests_run++; if (f_rst_o !== 1'b0) begin fails++; $display("FAIL idle_f_rst: got %b want 0", f_rst_o); end
    tests_run++; if (gnt_o !== '0) begin fails++; $display("FAIL idle_gnt: got %b want 0", gnt_o); end
  endtask

  task automatic test_directed;
    int ks[4] = '{0, 2, 2, 2};
    int as[4] = '{12, 123, 255, 0};
    int bs[4] = '{60, 223, 255, 0};
    int ys[4] = '{3, 11, 16, 0};
    logic [NREQ-1:0] g, d, eg;
    logic [Y_W-1:0] y;
    logic [A_W-1:0] al;
    logic [B_W-1:0] bl;
    int cyc, rsts, starts, lat, w, ecyc;
    bit err, to;
    for (int i = 0; i < 4; i++) begin
      a_bi = $urandom; b_bi = $urandom;
      a_bi[ks[i]*A_W +: A_W] = A_W'(as[i]);
      b_bi[ks[i]*B_W +: B_W] = B_W'(bs[i]);
      req_i = '0; req_i[PW'(ks[i])] = 1'b1;
      eg = req_i;
      w = pick(req_i, model_ptr);
      lat = $urandom_range(0, 5);
      ecyc = 5 + ((lat > 1) ? lat - 1 : 0);
      run_op(lat, 1'b0, g, d, y, al, bl, cyc, rsts, starts, err, to);
      req_i = '0;
      tests_run++; if (to) begin fails++; $display("FAIL dir%0d_timeout: no done within bound", i); end
      tests_run++; if (g !== eg) begin fails++; $display("FAIL dir%0d_gnt: got %b want %b", i, g, eg); end
      tests_run++; if (d !== eg) begin fails++; $display("FAIL dir%0d_done: got %b want %b", i, d, eg); end
      tests_run++; if (al !== A_W'(as[i]) || bl !== B_W'(bs[i])) begin fails++; $display("FAIL dir%0d_ops: got a=%0d b=%0d want a=%0d b=%0d", i, al, bl, as[i], bs[i]); end
      tests_run++; if (y !== Y_W'(ys[i])) begin fails++; $display("FAIL dir%0d_y: got %0d want %0d", i, y, ys[i]); end
      tests_run++; if (cyc != ecyc) begin fails++; $display("FAIL dir%0d_latency: got %0d want %0d", i, cyc, ecyc); end
      tests_run++; if (rsts != 1 || starts != 1) begin fails++; $display("FAIL dir%0d_pulses: got rst=%0d start=%0d want 1/1", i, rsts, starts); end
      tests_run++; if (err) begin fails++; $display("FAIL dir%0d_err: got 1 want 0", i); end
      model_ptr = (w + 1) % NREQ;
      idle(2);
    end
  endtask

  task automatic test_all_four;
    int order[5] = '{0, 1, 2, 3, 0};
    logic [NREQ-1:0] g, d, eg;
    logic [Y_W-1:0] y;
    logic [A_W-1:0] al;
    logic [B_W-1:0] bl;
    int cyc, rsts, starts, m0, b0;
    bit err, to;
    rst_n = 1'b0;
    a_bi = $urandom; b_bi = $urandom;
    req_i = '1;
    idle(2);
    rst_n = 1'b1;
    model_ptr = 0;
    m0 = multi_gnt; b0 = done_bad;
    for (int i = 0; i < 5; i++) begin
      run_op($urandom_range(0, 3), 1'b0, g, d, y, al, bl, cyc, rsts, starts, err, to);
      eg = '0; eg[PW'(order[i])] = 1'b1;
      tests_run++; if (to || d !== eg || g !== eg) begin fails++; $display("FAIL rr%0d_order: got gnt=%b done=%b want %b", i, g, d, eg); end
      tests_run++; if (y !== ref_func(a_bi[order[i]*A_W +: A_W])) begin fails++; $display("FAIL rr%0d_y: got %0d want %0d", i, y, ref_func(a_bi[order[i]*A_W +: A_W])); end
      model_ptr = (order[i] + 1) % NREQ;
    end
    req_i = '0;
    idle(2);
    tests_run++; if (multi_gnt != m0) begin fails++; $display("FAIL rr_onehot: got %0d multi-grant cycles want 0", multi_gnt - m0); end
    tests_run++; if (done_bad != b0) begin fails++; $display("FAIL rr_done_overlap: got %0d bad done cycles want 0", done_bad - b0); end
  endtask

  task automatic test_fairness;
    logic [NREQ-1:0] g, d;
    logic [Y_W-1:0] y;
    logic [A_W-1:0] al;
    logic [B_W-1:0] bl;
    int cyc, rsts, starts;
    bit err, to;
    req_i = 4'b0010;
    run_op(0, 1'b0, g, d, y, al, bl, cyc, rsts, starts, err, to);
    tests_run++; if (to || d !== 4'b0010) begin fails++; $display("FAIL fair_first: got %b want 0010", d); end
    model_ptr = 2;
    req_i = 4'b0011;
    run_op(1, 1'b0, g, d, y, al, bl, cyc, rsts, starts, err, to);
    tests_run++; if (to || d !== 4'b0001) begin fails++; $display("FAIL fair_second: got %b want 0001", d); end
    run_op(2, 1'b0, g, d, y, al, bl, cyc, rsts, starts, err, to);
    tests_run++; if (to || d !== 4'b0010) begin fails++; $display("FAIL fair_third: got %b want 0010", d); end
    req_i = '0;
    model_ptr = 2;
    idle(2);
  endtask

  task automatic test_random;
    logic [NREQ-1:0] g, d, eg, r;
    logic [Y_W-1:0] y;
    logic [A_W-1:0] al, ea;
    logic [B_W-1:0] bl, eb;
    int cyc, rsts, starts, lat, w, ecyc;
    bit err, to, scr;
    for (int i = 0; i < 40; i++) begin
      do r = NREQ'($urandom); while (r == '0);
      a_bi = $urandom; b_bi = $urandom; req_i = r;
      w = pick(r, model_ptr);
      eg = '0; eg[PW'(w)] = 1'b1;
      ea = a_bi[w*A_W +: A_W]; eb = b_bi[w*B_W +: B_W];
      lat = $urandom_range(0, 6);
      scr = 1'($urandom);
      ecyc = 5 + ((lat > 1) ? lat - 1 : 0);
      run_op(lat, scr, g, d, y, al, bl, cyc, rsts, starts, err, to);
      req_i = '0;
      tests_run++; if (to) begin fails++; $display("FAIL rnd%0d_timeout: no done within bound", i); end
      tests_run++; if (g !== eg || d !== eg) begin fails++; $display("FAIL rnd%0d_winner: got gnt=%b done=%b want %b (req %b)", i, g, d, eg, r); end
      tests_run++; if (al !== ea || bl !== eb) begin fails++; $display("FAIL rnd%0d_ops: got a=%0d b=%0d want a=%0d b=%0d", i, al, bl, ea, eb); end
      tests_run++; if (y !== ref_func(ea)) begin fails++; $display("FAIL rnd%0d_y: got %0d want %0d", i, y, ref_func(ea)); end
      tests_run++; if (cyc != ecyc) begin fails++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, cyc, ecyc); end
      tests_run++; if (rsts != 1 || starts != 1) begin fails++; $display("FAIL rnd%0d_pulses: got rst=%0d start=%0d want 1/1", i, rsts, starts); end
      tests_run++; if (err) begin fails++; $display("FAIL rnd%0d_err: got 1 want 0", i); end
      model_ptr = (w + 1) % NREQ;
      idle(2);
      tests_run++; if (y_bo !== ref_func(ea)) begin fails++; $display("FAIL rnd%0d_y_hold: got %0d want %0d", i, y_bo, ref_func(ea)); end
    end
  endtask

  task automatic test_reset_mid;
    logic [NREQ-1:0] g, d;
    logic [Y_W-1:0] y;
    logic [A_W-1:0] al;
    logic [B_W-1:0] bl;
    int cyc, rsts, starts, dc0;
    bit err, to;
    a_bi = $urandom; b_bi = $urandom;
    a_bi[0 +: A_W] = 8'd100;
    a_bi[2*A_W +: A_W] = 8'd77;
    req_i = 4'b0001;
    run_op(0, 1'b0, g, d, y, al, bl, cyc, rsts, starts, err, to);
    req_i = '0;
    tests_run++; if (to || d !== 4'b0001 || y !== 5'd10) begin fails++; $display("FAIL mid_setup: got done=%b y=%0d want 0001/10", d, y); end
    idle(2);
    req_i = 4'b0100;
    lat_sel = 20;
    idle(7);
    dc0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (f_rst_o !== 1'b1 || f_start_o !== 1'b0) begin fails++; $display("FAIL mid_func_ctl: got rst=%b start=%b want 1/0", f_rst_o, f_start_o); end
    tests_run++; if (gnt_o !== '0 || done_o !== '0) begin fails++; $display("FAIL mid_gnt_done: got gnt=%b done=%b want 0/0", gnt_o, done_o); end
    tests_run++; if (y_bo !== '0 || f_a_bo !== '0 || f_b_bo !== '0) begin fails++; $display("FAIL mid_data: got y=%0d a=%0d b=%0d want 0", y_bo, f_a_bo, f_b_bo); end
    idle(3);
    req_i = 4'b0011;
    rst_n = 1'b1;
    model_ptr = 0;
    tests_run++; if (done_cnt != dc0) begin fails++; $display("FAIL mid_no_done: got %0d done pulses want 0", done_cnt - dc0); end
    run_op(0, 1'b0, g, d, y, al, bl, cyc, rsts, starts, err, to);
    req_i = '0;
    tests_run++; if (to || d !== 4'b0001) begin fails++; $display("FAIL mid_ptr_reset: got %b want 0001", d); end
    model_ptr = 1;
    idle(2);
  endtask

`ifdef FUNC_ARB_TIMEOUT_EN
  task automatic test_timeout;
    logic [NREQ-1:0] g, d;
    logic [Y_W-1:0] y;
    logic [A_W-1:0] al;
    logic [B_W-1:0] bl;
    int cyc, rsts, starts;
    bit err, to;
    stuck = 1'b1;
    req_i = 4'b0001;
    run_op(0, 1'b0, g, d, y, al, bl, cyc, rsts, starts, err, to);
    req_i = '0;
    stuck = 1'b0;
    tests_run++; if (to || d !== 4'b0001) begin fails++; $display("FAIL to_done: got %b want 0001", d); end
    tests_run++; if (!err) begin fails++; $display("FAIL to_err: got 0 want 1"); end
    tests_run++; if (y !== 5'd31) begin fails++; $display("FAIL to_y: got %0d want 31", y); end
    idle(2);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_all_four();
    test_fairness();
    test_random();
    test_reset_mid();
`ifdef FUNC_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/func_arbiter.md
Name: func_arbiter

Overview:
- Shares one `func` compute unit between NREQ requesters using round-robin arbitration.
- Per operation: latches the winner's operands, pulses the unit's reset, launches it with a start pulse, waits for busy to clear, then returns the result with a one-cycle done pulse.
- Sits between requester blocks and a single `func` instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- A_W, 8, operand A width.
- B_W, 8, operand B width.
- Y_W, 5, result width.
- TIMEOUT_CYC, 255, watchdog limit in cycles; used only with FUNC_ARB_TIMEOUT_EN.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-low reset.
- req_i  input  NREQ  per-requester request level.
- a_bi  input  NREQ*A_W  operands A, requester k at [k*A_W +: A_W].
- b_bi  input  NREQ*B_W  operands B, packed the same way.
- gnt_o  output  NREQ  one-hot grant, held for the whole operation.
- done_o  output  NREQ  one-hot, one-cycle completion pulse.
- y_bo  output  Y_W  result; valid in the done cycle, held until the next done.
- f_rst_o  output  1  active-high reset to `func`.
- f_a_bo  output  A_W  operand A to `func`.
- f_b_bo  output  B_W  operand B to `func`.
- f_start_o  output  1  start pulse to `func`.
- f_busy_i  input  2  `func` busy; nonzero means computing.
- f_y_bi  input  Y_W  `func` result.

Behaviour:
- Reset values (asserted asynchronously, all outputs registered):
  - f_rst_o = 1.
  - gnt_o, done_o, y_bo, f_a_bo, f_b_bo, f_start_o = 0.
  - State = IDLE, round-robin pointer = 0.
- IDLE (f_rst_o = 0): on an edge where req_i != 0:
  - Pick the first set bit scanning from the pointer upward, with wrap-around.
  - Latch that requester's operands into f_a_bo/f_b_bo.
  - Set gnt_o. Go to CLR.
- CLR: f_rst_o = 1 for exactly one cycle. Go to LAUNCH.
- LAUNCH: f_start_o = 1 for exactly one cycle. Go to GUARD.
- GUARD: one cycle; f_busy_i is ignored, which covers busy's rise latency. Go to WAIT.
- WAIT: remain while f_busy_i != 0. On the first edge with f_busy_i == 0, capture f_y_bi into y_bo and go to RESP.
- RESP:
  - done_o = gnt_o for one cycle; the pointer becomes (winner+1) mod NREQ.
  - gnt_o clears on leaving RESP. Go to IDLE.
- Latency: with request seen at edge t, done_o is high during cycle t+4+W, where W = number of WAIT cycles with busy nonzero (minimum W = 0, giving t+4).
- Requester protocol:
  - Operands are sampled only at the grant edge; later changes are ignored.
  - Deasserting req_i mid-operation does not abort; done still pulses.
  - req_i still high in the cycle after done counts as a new request, arbitrated fairly against the others.
- Back-to-back: at most one operation is in flight. The arbiter returns to IDLE for one cycle between operations, so minimum issue spacing is 6 cycles.
- Simultaneous requests: strict round-robin. Starvation-free: every asserted request is served within NREQ operations.
- Reset mid-operation (async):
  - Aborts immediately; no done pulse is issued.
  - All outputs return to reset values, including f_rst_o = 1 holding `func` in reset.
  - Requesters must re-request.
- f_busy_i is treated as boolean (any nonzero bit means busy).

Optional Feature:
- Macro FUNC_ARB_TIMEOUT_EN.
- Defined:
  - Adds a counter that clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC with busy still nonzero, go to RESP with y_bo = all ones. Adds output err_o (1 bit, reset 0), pulsed with done_o on timeout.
  - The pointer advances as normal.
- Undefined: no counter and no err_o port; WAIT waits indefinitely.

Test Plan:
- Single request: req_i=0001, operands a=12, b=60 → gnt_o=0001, one f_rst_o pulse, then one f_start_o pulse, done_o=0001, y_bo=3.
- Requester 2 with a=123, b=223 → done_o=0100, y_bo=11; a=255, b=255 → y_bo=16; a=0, b=0 → y_bo=0.
- All four requests held high from reset → grants in order 0,1,2,3,0; exactly one gnt_o bit high at any time; no done_o overlap.
- Fairness: requester 1 served, then req_i=0011 held → requester 0 is served before 1 again.
- rst_i driven low during WAIT → outputs immediately at reset values, f_rst_o=1, no done pulse. After release, a pending request is re-served from pointer 0.
- Timeout (FUNC_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=16, f_busy_i forced to 01 by a stub) → err_o and done_o pulse together, y_bo=31.
